// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: long-latency write scoreboard, RAW/WAW stall,
// redirect flush sequencing and FENCE drain for the IF/ID/EX core.
//
// state | meaning
// RUN   | normal issue, stall on scoreboard hazard or busy EX
// FLUSH | redirect in progress, IF/ID cleared, issue suppressed
// DRAIN | FENCE held in ID until scoreboard empty and EX idle
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_NUM      = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_reg1_raddr_i,
  input  logic [4:0]  id_reg2_raddr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        id_reg_wen_i,
  input  logic [4:0]  id_reg_waddr_i,
  input  logic        id_long_i,
  input  logic        id_fence_i,
  input  logic        ex_busy_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        wb_long_done_i,
  input  logic [4:0]  wb_long_waddr_i,
  output logic        issue_o,
  output logic        hold_if_o,
  output logic        hold_id_o,
  output logic        flush_if_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] pending_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] sb_q, sb_d;

  logic hz;
  logic issue, hold, flush, jump;
  logic [31:0] jump_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
    end
  end

  // Only the registered scoreboard is consulted: a retirement this cycle
  // releases the stall on the following cycle.
  always_comb begin
    hz = 1'b0;
    if (id_rs1_used_i && (id_reg1_raddr_i != 5'd0) && sb_q[id_reg1_raddr_i]) hz = 1'b1;
    if (id_rs2_used_i && (id_reg2_raddr_i != 5'd0) && sb_q[id_reg2_raddr_i]) hz = 1'b1;
    if (id_reg_wen_i && (id_reg_waddr_i != 5'd0) && sb_q[id_reg_waddr_i]) hz = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ex_jump_i) begin
      state_d = ST_FLUSH;
      cnt_d   = FLUSH_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (id_valid_i && id_fence_i) state_d = ST_DRAIN;
        end
        ST_FLUSH: begin
          if (cnt_q == 4'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_DRAIN: begin
          if (issue) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    issue     = 1'b0;
    hold      = 1'b0;
    flush     = 1'b0;
    jump      = 1'b0;
    jump_addr = 32'h0;
    if (!rst_n_i) begin
      issue = 1'b0;
    end else if (ex_jump_i) begin
      jump      = 1'b1;
      jump_addr = ex_jump_addr_i;
      flush     = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          issue = id_valid_i && !hz && !ex_busy_i && !id_fence_i;
          hold  = id_valid_i && !issue;
        end
        ST_FLUSH: flush = 1'b1;
        ST_DRAIN: begin
          hold  = (sb_q != 32'h0) || ex_busy_i;
          issue = id_valid_i && !hold;
        end
        default: issue = 1'b0;
      endcase
    end
  end

  // Clear first, then set, so a same-cycle retire/issue to one register keeps it pending.
  always_comb begin
    sb_d = sb_q;
    if (wb_long_done_i) sb_d[wb_long_waddr_i] = 1'b0;
    if (issue && id_reg_wen_i && id_long_i && (id_reg_waddr_i != 5'd0))
      sb_d[id_reg_waddr_i] = 1'b1;
    for (int n = 0; n < 32; n++) begin
      if ((n == 0) || (n >= REG_NUM)) sb_d[n] = 1'b0;
    end
  end

  assign issue_o     = issue;
  assign hold_if_o   = hold;
  assign hold_id_o   = hold;
  assign flush_if_o  = flush;
  assign jump_o      = jump;
  assign jump_addr_o = jump_addr;
  assign pending_o   = rst_n_i ? sb_q : 32'h0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle vector table with expected outputs
// queued at drive time and compared shortly after the falling edge.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        rst_n;
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        wen;
    logic [4:0]  rd;
    logic        lng;
    logic        fen;
    logic        busy;
    logic        jmp;
    logic [31:0] ja;
    logic        wbd;
    logic [4:0]  wba;
  } in_t;

  typedef struct packed {
    logic        issue;
    logic        hold_if;
    logic        hold_id;
    logic        flush;
    logic        jump;
    logic [31:0] jaddr;
    logic [31:0] pend;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string nm;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i, id_valid_i, id_rs1_used_i, id_rs2_used_i, id_reg_wen_i;
  logic [4:0]  id_reg1_raddr_i, id_reg2_raddr_i, id_reg_waddr_i, wb_long_waddr_i;
  logic        id_long_i, id_fence_i, ex_busy_i, ex_jump_i, wb_long_done_i;
  logic [31:0] ex_jump_addr_i;
  logic        issue_o, hold_if_o, hold_id_o, flush_if_o, jump_o;
  logic [31:0] jump_addr_o, pending_o;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t  tbl[$];
  out_t  exp_q[$];
  string nm_q[$];

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.FLUSH_CYCLES(2), .REG_NUM(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
    .id_reg1_raddr_i(id_reg1_raddr_i), .id_reg2_raddr_i(id_reg2_raddr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_reg_wen_i(id_reg_wen_i), .id_reg_waddr_i(id_reg_waddr_i),
    .id_long_i(id_long_i), .id_fence_i(id_fence_i), .ex_busy_i(ex_busy_i),
    .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i),
    .wb_long_done_i(wb_long_done_i), .wb_long_waddr_i(wb_long_waddr_i),
    .issue_o(issue_o), .hold_if_o(hold_if_o), .hold_id_o(hold_id_o),
    .flush_if_o(flush_if_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o),
    .pending_o(pending_o)
  );

  function automatic in_t ins(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic wen, logic [4:0] rd, logic lng, logic fen);
    in_t r = '0;
    r.rst_n = 1'b1; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.wen = wen; r.rd = rd; r.lng = lng; r.fen = fen;
    return r;
  endfunction

  function automatic in_t nop();
    return ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic in_t fence();
    return ins(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction
  function automatic in_t busy(in_t a);
    in_t r = a; r.busy = 1'b1; return r;
  endfunction
  function automatic in_t jmp(in_t a, logic [31:0] addr);
    in_t r = a; r.jmp = 1'b1; r.ja = addr; return r;
  endfunction
  function automatic in_t wb(in_t a, logic [4:0] addr);
    in_t r = a; r.wbd = 1'b1; r.wba = addr; return r;
  endfunction
  function automatic in_t rst(in_t a);
    in_t r = a; r.rst_n = 1'b0; return r;
  endfunction

  function automatic out_t mo(logic issue, logic hold, logic flush, logic jump,
                              logic [31:0] ja, logic [31:0] pend);
    out_t r;
    r.issue = issue; r.hold_if = hold; r.hold_id = hold; r.flush = flush;
    r.jump = jump; r.jaddr = ja; r.pend = pend;
    return r;
  endfunction

  task automatic add(input in_t i, input out_t o, input string nm);
    vec_t v;
    v.i = i; v.o = o; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic step(input in_t i, input out_t o, input string nm);
    out_t got, want;
    string wn;
    @(negedge clk_i);
    rst_n_i = i.rst_n; id_valid_i = i.v;
    id_reg1_raddr_i = i.rs1; id_rs1_used_i = i.u1;
    id_reg2_raddr_i = i.rs2; id_rs2_used_i = i.u2;
    id_reg_wen_i = i.wen; id_reg_waddr_i = i.rd; id_long_i = i.lng; id_fence_i = i.fen;
    ex_busy_i = i.busy; ex_jump_i = i.jmp; ex_jump_addr_i = i.ja;
    wb_long_done_i = i.wbd; wb_long_waddr_i = i.wba;
    exp_q.push_back(o);
    nm_q.push_back(nm);
    #1;
    got.issue = issue_o; got.hold_if = hold_if_o; got.hold_id = hold_id_o;
    got.flush = flush_if_o; got.jump = jump_o; got.jaddr = jump_addr_o; got.pend = pending_o;
    want = exp_q.pop_front();
    wn   = nm_q.pop_front();
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got issue=%b hold=%b%b flush=%b jump=%b addr=%h pend=%h, want issue=%b hold=%b%b flush=%b jump=%b addr=%h pend=%h",
                  wn, got.issue, got.hold_if, got.hold_id, got.flush, got.jump, got.jaddr, got.pend,
                  want.issue, want.hold_if, want.hold_id, want.flush, want.jump, want.jaddr, want.pend);
  endtask

  initial begin
    int d;
    rst_n_i = 0; id_valid_i = 0; id_reg1_raddr_i = 0; id_reg2_raddr_i = 0;
    id_rs1_used_i = 0; id_rs2_used_i = 0; id_reg_wen_i = 0; id_reg_waddr_i = 0;
    id_long_i = 0; id_fence_i = 0; ex_busy_i = 0; ex_jump_i = 0; ex_jump_addr_i = 0;
    wb_long_done_i = 0; wb_long_waddr_i = 0;

    // reset
    add(jmp(rst(ins(1, 1, 1, 2, 1, 1, 3, 1, 0)), 32'h1234), mo(0, 0, 0, 0, 0, 0), "reset_gate");
    add(rst(nop()), mo(0, 0, 0, 0, 0, 0), "reset_idle");
    // load-use
    add(ins(1, 0, 0, 0, 0, 1, 5, 1, 0), mo(1, 0, 0, 0, 0, 0), "lu_issue_x5");
    add(ins(1, 5, 1, 0, 0, 1, 6, 0, 0), mo(0, 1, 0, 0, 0, 32'h20), "lu_stall1");
    add(ins(1, 5, 1, 0, 0, 1, 6, 0, 0), mo(0, 1, 0, 0, 0, 32'h20), "lu_stall2");
    add(wb(ins(1, 5, 1, 0, 0, 1, 6, 0, 0), 5), mo(0, 1, 0, 0, 0, 32'h20), "lu_stall_retire");
    add(ins(1, 5, 1, 0, 0, 1, 6, 0, 0), mo(1, 0, 0, 0, 0, 0), "lu_release");
    add(ins(1, 0, 0, 0, 0, 1, 9, 1, 0), mo(1, 0, 0, 0, 0, 0), "issue_x9");
    add(ins(1, 0, 0, 9, 1, 0, 0, 0, 0), mo(0, 1, 0, 0, 0, 32'h200), "rs2_stall");
    add(ins(1, 9, 0, 9, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 32'h200), "unused_src");
    add(wb(nop(), 9), mo(0, 0, 0, 0, 0, 32'h200), "retire_x9");
    add(nop(), mo(0, 0, 0, 0, 0, 0), "x9_clear");
    // x0 and WAW
    add(ins(1, 0, 0, 0, 0, 1, 0, 1, 0), mo(1, 0, 0, 0, 0, 0), "long_x0");
    add(ins(1, 0, 0, 0, 0, 1, 7, 1, 0), mo(1, 0, 0, 0, 0, 0), "x0_not_set");
    add(ins(1, 0, 0, 0, 0, 1, 7, 0, 0), mo(0, 1, 0, 0, 0, 32'h80), "waw_stall");
    add(wb(ins(1, 0, 0, 0, 0, 1, 7, 0, 0), 7), mo(0, 1, 0, 0, 0, 32'h80), "waw_retire");
    add(ins(1, 0, 0, 0, 0, 1, 7, 0, 0), mo(1, 0, 0, 0, 0, 0), "waw_release");
    add(busy(ins(1, 1, 1, 2, 1, 1, 8, 0, 0)), mo(0, 1, 0, 0, 0, 0), "ex_busy_stall");
    // same-cycle retire and set of x3
    add(wb(ins(1, 0, 0, 0, 0, 1, 3, 1, 0), 3), mo(1, 0, 0, 0, 0, 0), "setclr_x3");
    add(wb(nop(), 12), mo(0, 0, 0, 0, 0, 32'h8), "set_wins");
    add(nop(), mo(0, 0, 0, 0, 0, 32'h8), "nop_retire");
    // redirect
    add(jmp(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), 32'h8000_0040), mo(0, 0, 1, 1, 32'h8000_0040, 32'h8), "redirect");
    add(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), mo(0, 0, 1, 0, 0, 32'h8), "flush1");
    add(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), mo(0, 0, 1, 0, 0, 32'h8), "flush2");
    add(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 32'h8), "flush_done");
    // jump during FLUSH
    add(jmp(nop(), 32'h200), mo(0, 0, 1, 1, 32'h200, 32'h8), "jump_a");
    add(jmp(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), 32'h100), mo(0, 0, 1, 1, 32'h100, 32'h8), "rejump");
    add(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), mo(0, 0, 1, 0, 0, 32'h8), "reflush1");
    add(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), mo(0, 0, 1, 0, 0, 32'h8), "reflush2");
    add(wb(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), 3), mo(1, 0, 0, 0, 0, 32'h8), "rejump_done");
    // FENCE drain
    add(ins(1, 0, 0, 0, 0, 1, 10, 1, 0), mo(1, 0, 0, 0, 0, 0), "issue_x10");
    add(busy(fence()), mo(0, 1, 0, 0, 0, 32'h400), "fence_hold");
    add(busy(fence()), mo(0, 1, 0, 0, 0, 32'h400), "drain_hold");
    add(wb(busy(fence()), 10), mo(0, 1, 0, 0, 0, 32'h400), "drain_retire");
    add(busy(fence()), mo(0, 1, 0, 0, 0, 0), "drain_busy");
    add(fence(), mo(1, 0, 0, 0, 0, 0), "fence_issue");
    add(fence(), mo(0, 1, 0, 0, 0, 0), "back_in_run");
    add(fence(), mo(1, 0, 0, 0, 0, 0), "fence_quick");
    // jump aborts DRAIN
    add(ins(1, 0, 0, 0, 0, 1, 10, 1, 0), mo(1, 0, 0, 0, 0, 0), "issue_x10b");
    add(fence(), mo(0, 1, 0, 0, 0, 32'h400), "fence_hold_b");
    add(jmp(fence(), 32'h300), mo(0, 0, 1, 1, 32'h300, 32'h400), "drain_abort");
    add(nop(), mo(0, 0, 1, 0, 0, 32'h400), "abort_flush1");
    add(nop(), mo(0, 0, 1, 0, 0, 32'h400), "abort_flush2");
    add(ins(1, 2, 1, 0, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 32'h400), "after_abort");
    // reset during FLUSH
    add(jmp(nop(), 32'h40), mo(0, 0, 1, 1, 32'h40, 32'h400), "jump_pre_reset");
    add(rst(ins(1, 1, 1, 0, 0, 0, 0, 0, 0)), mo(0, 0, 0, 0, 0, 0), "reset_in_flush");
    add(ins(1, 10, 1, 0, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0), "post_reset");

    foreach (tbl[k]) step(tbl[k].i, tbl[k].o, tbl[k].nm);

    // drain with a random retirement delay
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(1, 4);
      step(ins(1, 0, 0, 0, 0, 1, 4, 1, 0), mo(1, 0, 0, 0, 0, 0), "drn_issue");
      step(busy(fence()), mo(0, 1, 0, 0, 0, 32'h10), "drn_enter");
      for (int k = 0; k < d; k++) step(busy(fence()), mo(0, 1, 0, 0, 0, 32'h10), "drn_wait");
      step(wb(busy(fence()), 4), mo(0, 1, 0, 0, 0, 32'h10), "drn_retire");
      step(fence(), mo(1, 0, 0, 0, 0, 0), "drn_go");
    end

    // reset during DRAIN
    step(ins(1, 0, 0, 0, 0, 1, 4, 1, 0), mo(1, 0, 0, 0, 0, 0), "rd_issue_x4");
    step(busy(fence()), mo(0, 1, 0, 0, 0, 32'h10), "rd_fence");
    step(busy(fence()), mo(0, 1, 0, 0, 0, 32'h10), "rd_drain");
    step(rst(busy(fence())), mo(0, 0, 0, 0, 0, 0), "rd_reset");
    step(fence(), mo(0, 1, 0, 0, 0, 0), "rd_run_fence");
    step(fence(), mo(1, 0, 0, 0, 0, 0), "rd_fence_issue");
    step(ins(1, 4, 1, 0, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 0), "rd_x4_cleared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the IF/ID/EX core.
- Keeps a scoreboard of registers with outstanding long-latency writes (loads, multicycle ops) and stalls ID on RAW/WAW hazards against it.
- Sequences branch/jump redirects by flushing IF/ID for a fixed number of cycles, and drains the pipe for FENCE.
- Drives the hold/flush inputs of the IF and ID pipeline registers and the PC redirect.

Parameters:
- FLUSH_CYCLES, 2, cycles that issue is suppressed after a redirect (1..15).
- REG_NUM, 32, number of GP registers tracked; x0 is never tracked.

Ports:
- clk_i  input  1  core clock
- rst_n_i  input  1  reset, active-low, synchronous to clk_i
- id_valid_i  input  1  ID holds a decoded instruction
- id_reg1_raddr_i  input  5  rs1 address from decode
- id_reg2_raddr_i  input  5  rs2 address from decode
- id_rs1_used_i  input  1  instruction reads rs1
- id_rs2_used_i  input  1  instruction reads rs2
- id_reg_wen_i  input  1  instruction writes rd
- id_reg_waddr_i  input  5  rd address
- id_long_i  input  1  rd write completes later via wb_long_*
- id_fence_i  input  1  instruction is FENCE
- ex_busy_i  input  1  multicycle EX unit occupied
- ex_jump_i  input  1  EX resolves a taken branch or jump this cycle
- ex_jump_addr_i  input  32  redirect target
- wb_long_done_i  input  1  long-latency write retires this cycle
- wb_long_waddr_i  input  5  register retired
- issue_o  output  1  ID instruction advances to EX this cycle
- hold_if_o  output  1  freeze PC and IF/ID register
- hold_id_o  output  1  freeze ID/EX input (insert bubble into EX)
- flush_if_o  output  1  clear IF/ID register to NOP
- jump_o  output  1  PC redirect strobe
- jump_addr_o  output  32  PC redirect target
- pending_o  output  32  scoreboard, bit n = xn write outstanding

Behaviour:
- Reset (rst_n_i low at posedge): state RUN, flush counter 0, scoreboard 0. While in reset, all outputs are 0; jump_addr_o is 32'h0.
- FSM states: RUN, FLUSH, DRAIN.
- Hazard: hz is 1 if either condition holds:
  - (rs1_used and rs1!=0 and pending[rs1]) or (rs2_used and rs2!=0 and pending[rs2]);
  - id_reg_wen_i and rd!=0 and pending[rd] (WAW).
- Hazard checks use the registered scoreboard only. A same-cycle wb_long_done does not bypass, so the stall releases one cycle after retirement.
- In RUN, issue_o = id_valid_i & ~hz & ~ex_busy_i & ~ex_jump_i & ~id_fence_i.
- Stall: hold_if_o = hold_id_o = id_valid_i & ~issue_o & ~ex_jump_i.
- Jump (any state, highest priority):
  - jump_o = ex_jump_i and jump_addr_o = ex_jump_addr_i, combinational. jump_addr_o is 0 when there is no jump.
  - flush_if_o = 1 and issue_o = 0 in the same cycle.
  - Next state is FLUSH with counter = FLUSH_CYCLES-1.
  - A jump during FLUSH reloads the counter. A jump during DRAIN aborts the drain to FLUSH.
- FLUSH:
  - issue_o = 0, flush_if_o = 1, holds 0.
  - Counter decrements each cycle. When the counter is 0, the next state is RUN.
- FENCE: in RUN with id_valid_i & id_fence_i, go to DRAIN. The FENCE is held in ID (hold_if_o = hold_id_o = 1).
- DRAIN:
  - Holds asserted while the scoreboard is nonzero or ex_busy_i = 1.
  - The first cycle both are clear, issue_o = 1 (FENCE issues) and the next state is RUN.
- Scoreboard update per cycle:
  - Clear bit wb_long_waddr_i if wb_long_done_i.
  - Then set bit id_reg_waddr_i if issue_o & id_reg_wen_i & id_long_i & rd!=0.
  - If the same register is cleared and set in one cycle, the set wins (result 1).
  - Bit 0 is always 0. Retiring a non-pending register is a no-op.
- pending_o is the registered scoreboard.
- Reset mid-FLUSH or mid-DRAIN returns to RUN with the scoreboard cleared.

Test Plan:
- Load-use stall:
  - Stimulus: issue long write x5 (id_long_i=1); next ID instruction reads rs1=5; wb_long_done x5 two cycles later.
  - Required: pending_o=32'h20; issue_o=0 with holds=1 for 3 cycles; issue_o=1 the cycle after pending_o returns to 0.
- x0 and WAW:
  - Stimulus: long write to rd=0, then long write to rd=7, then a write to rd=7.
  - Required: pending_o stays 0 after rd=0; the second rd=7 write stalls until x7 retires.
- Redirect:
  - Stimulus: ex_jump_i=1 with addr 32'h8000_0040, FLUSH_CYCLES=2.
  - Required: jump_o=1 and jump_addr_o=32'h8000_0040 for 1 cycle; flush_if_o=1 for 3 cycles total; issue_o=0 throughout.
- Jump during FLUSH:
  - Stimulus: a second jump to 32'h100 in the first FLUSH cycle.
  - Required: counter reloads; flush_if_o stays high 2 further cycles; jump_addr_o=32'h100.
- FENCE drain:
  - Stimulus: pending_o=32'h400 and ex_busy_i=1, FENCE in ID; x10 retires, then ex_busy_i drops.
  - Required: holds asserted until both clear; issue_o=1 exactly once; state returns to RUN.
- Simultaneous set/clear and reset:
  - Stimulus: wb retire x3 in the same cycle as a new long issue to x3; then rst_n_i=0 while in FLUSH.
  - Required: pending_o bit 3 = 1 after the set/clear cycle; after the reset cycle, all outputs are 0.
